nn_mlp_seq: RTL and testbench

Time-multiplexed, parametrised successor to the combinational 2-input MLP used in the neural-network PLL loop filter. It computes y = sat(b2 + w2x·x2 + Σj w2j·act(b1j + w1j0·x1 + w1j1·x2)) for NH hidden neurons using a single shared multiplier. Weights and biases are runtime-programmable through a config write port. Inputs and outputs use valid/ready handshakes, so the block drops between the phase-detector sampler and the DCO control register.

---
 rtl/nn_mlp_seq.sv | 191 +++++++++++++++++++
 tb/tb_nn_mlp_seq.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_mlp_seq.sv
// rtl/nn_mlp_seq.sv - time-multiplexed 2-input MLP, one shared multiplier, programmable coefficients
module nn_mlp_seq #(
  parameter int DW   = 9,
  parameter int WW   = 8,
  parameter int NH   = 3,
  parameter int FRAC = 6,
  parameter int OW   = 8,
  parameter int AW   = $clog2(4*NH+2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] x1,
  input  logic signed [DW-1:0] x2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OW-1:0]        out1,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic signed [WW-1:0] cfg_data
);

  localparam int NC   = 4*NH + 2;
  localparam int CW   = $clog2(NC);
  localparam int JW   = (NH > 1) ? $clog2(NH) : 1;
  localparam int PW   = WW + DW;
  localparam int ACCW = DW + WW + $clog2(NH+2) + 2;
  localparam int HMAX = 2**(DW-1) - 1;
  localparam int OMAX = 2**OW - 1;

  localparam logic signed [ACCW-1:0] HMAX_A = ACCW'(HMAX);
  localparam logic signed [ACCW-1:0] OMAX_A = ACCW'(OMAX);
  localparam logic [CW-1:0] IDX_W2X = CW'(4*NH);
  localparam logic [CW-1:0] IDX_B2  = CW'(4*NH+1);
  localparam logic [CW-1:0] IDX_W2  = CW'(3*NH);

  typedef enum logic [2:0] {
    S_IDLE, S_HA, S_HB, S_ACT, S_OB, S_OJ, S_FIN, S_DONE
  } state_t;

  state_t                 state;
  logic signed [WW-1:0]   coef [NC];
  logic [DW-1:0]          h [NH];
  logic signed [DW-1:0]   x1_r;
  logic signed [DW-1:0]   x2_r;
  logic [JW-1:0]          j;
  logic signed [ACCW-1:0] acc;

  logic [CW-1:0]          j3;
  logic signed [WW-1:0]   mul_w;
  logic signed [DW-1:0]   mul_x;
  logic signed [ACCW-1:0] base;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] acc_next;

  function automatic logic signed [ACCW-1:0] bias_ext(input logic signed [WW-1:0] b);
    bias_ext = ACCW'(b) <<< FRAC;
  endfunction

  // Hidden activation: ReLU that also saturates to the positive range of an input word.
  function automatic logic [DW-1:0] act(input logic signed [ACCW-1:0] s);
    logic signed [ACCW-1:0] q;
    q = s >>> FRAC;
    if (q[ACCW-1])
      act = '0;
    else if (q > HMAX_A)
      act = DW'(HMAX);
    else
      act = q[DW-1:0];
  endfunction

  function automatic logic [OW-1:0] sat(input logic signed [ACCW-1:0] s);
    logic signed [ACCW-1:0] q;
    q = s >>> FRAC;
    if (q[ACCW-1])
      sat = '0;
    else if (q > OMAX_A)
      sat = OW'(OMAX);
    else
      sat = q[OW-1:0];
  endfunction

  // Operand selection for the single multiplier; base is either a shifted bias or the running sum.
  always_comb begin
    j3    = CW'(j) * CW'(3);
    mul_w = '0;
    mul_x = '0;
    base  = '0;
    case (state)
      S_HA: begin
        mul_w = coef[j3];
        mul_x = x1_r;
        base  = bias_ext(coef[j3 + CW'(2)]);
      end
      S_HB: begin
        mul_w = coef[j3 + CW'(1)];
        mul_x = x2_r;
        base  = acc;
      end
      S_OB: begin
        mul_w = coef[IDX_W2X];
        mul_x = x2_r;
        base  = bias_ext(coef[IDX_B2]);
      end
      S_OJ: begin
        mul_w = coef[IDX_W2 + CW'(j)];
        mul_x = $signed(h[j]);
        base  = acc;
      end
      default: ;
    endcase
  end

  assign prod     = mul_w * mul_x;
  assign acc_next = base + ACCW'(prod);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out1      <= '0;
      j         <= '0;
      acc       <= '0;
      x1_r      <= '0;
      x2_r      <= '0;
      for (int i = 0; i < NC; i++) coef[i] <= '0;
      for (int i = 0; i < NH; i++) h[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_we && (int'(cfg_addr) < NC))
            coef[cfg_addr] <= cfg_data;
          if (in_valid) begin
            x1_r     <= x1;
            x2_r     <= x2;
            j        <= '0;
            in_ready <= 1'b0;
            state    <= S_HA;
          end
        end
        S_HA: begin
          acc   <= acc_next;
          state <= S_HB;
        end
        S_HB: begin
          acc   <= acc_next;
          state <= S_ACT;
        end
        S_ACT: begin
          h[j] <= act(acc);
          if (j == JW'(NH-1)) begin
            j     <= '0;
            state <= S_OB;
          end else begin
            j     <= j + 1'b1;
            state <= S_HA;
          end
        end
        S_OB: begin
          acc   <= acc_next;
          state <= S_OJ;
        end
        S_OJ: begin
          acc <= acc_next;
          if (j == JW'(NH-1)) begin
            j     <= '0;
            state <= S_FIN;
          end else begin
            j <= j + 1'b1;
          end
        end
        S_FIN: begin
          out1      <= sat(acc);
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_mlp_seq.sv
// tb/tb_nn_mlp_seq.sv - scoreboard bench for nn_mlp_seq
module tb_nn_mlp_seq;

  localparam int DW  = 9;
  localparam int WW  = 8;
  localparam int NH  = 3;
  localparam int FRAC = 6;
  localparam int OW  = 8;
  localparam int AW  = 4;
  localparam int NC  = 4*NH + 2;
  localparam int LAT = 4*NH + 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] x1;
  logic signed [DW-1:0] x2;
  logic                 out_valid;
  logic                 out_ready;
  logic [OW-1:0]        out1;
  logic                 cfg_we;
  logic [AW-1:0]        cfg_addr;
  logic signed [WW-1:0] cfg_data;

  int total = 0;
  int bad   = 0;
  int sh [NC];
  int exp_q [$];

  always #5 clk = ~clk;

  nn_mlp_seq #(.DW(DW), .WW(WW), .NH(NH), .FRAC(FRAC), .OW(OW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2),
    .out_valid(out_valid), .out_ready(out_ready), .out1(out1),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
  );

  function automatic int clampi(int v, int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic int model(int a, int b);
    int hv [NH];
    int s;
    int acc;
    for (int k = 0; k < NH; k++) begin
      s = sh[3*k+2] * 64 + sh[3*k] * a + sh[3*k+1] * b;
      hv[k] = clampi(s >>> FRAC, 255);
    end
    acc = sh[4*NH+1] * 64 + sh[4*NH] * b;
    for (int k = 0; k < NH; k++) acc += sh[3*NH+k] * hv[k];
    return clampi(acc >>> FRAC, 255);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NC; i++) sh[i] = 0;
    exp_q.delete();
  endtask

  task automatic cfg_write(input int a, input int d);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = AW'(a);
    cfg_data = WW'(d);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    if (a < NC) sh[a] = d;
  endtask

  task automatic drive(input int a, input int b, input int e);
    @(negedge clk);
    x1 = DW'(a);
    x2 = DW'(b);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic collect(output int val, output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    val = int'(out1);
    if (out_ready === 1'b1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    int v, l, e;
    do_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (out1 !== 8'd0) begin bad++; $display("FAIL reset_out1 got=%0d want=0", out1); end
    drive(100, 50, 0);
    collect(v, l);
    e = exp_q.pop_front();
    total++; if (l !== LAT) begin bad++; $display("FAIL reset_latency got=%0d want=%0d", l, LAT); end
    total++; if (v !== e) begin bad++; $display("FAIL reset_zero_out got=%0d want=%0d", v, e); end
  endtask

  task automatic test_w2x();
    int tx2 [3] = '{100, -20, 255};
    int tex [3] = '{100, 0, 255};
    int v, l, e;
    do_reset();
    cfg_write(12, 64);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) cfg_write(12, 127);
      drive(7, tx2[i], tex[i]);
      collect(v, l);
      e = exp_q.pop_front();
      total++; if (l !== LAT) begin bad++; $display("FAIL w2x_latency[%0d] got=%0d want=%0d", i, l, LAT); end
      total++; if (v !== e) begin bad++; $display("FAIL w2x_out[%0d] got=%0d want=%0d", i, v, e); end
    end
  endtask

  task automatic test_hidden();
    int tx1 [3] = '{37, -37, 255};
    int tex [3] = '{37, 0, 255};
    int v, l, e;
    do_reset();
    cfg_write(0, 64);
    cfg_write(9, 64);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) cfg_write(0, 127);
      drive(tx1[i], -90, tex[i]);
      collect(v, l);
      e = exp_q.pop_front();
      total++; if (v !== e) begin bad++; $display("FAIL hidden_out[%0d] got=%0d want=%0d", i, v, e); end
    end
  endtask

  task automatic test_cfg_guard();
    int v, l, e;
    do_reset();
    cfg_write(13, 10);
    drive(3, -7, 10);
    collect(v, l);
    e = exp_q.pop_front();
    total++; if (v !== e) begin bad++; $display("FAIL guard_b2 got=%0d want=%0d", v, e); end
    // second sample: write b2=5 while the FSM sits in HB
    @(negedge clk);
    x1 = 9'sd20;
    x2 = 9'sd30;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_q.push_back(10);
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = 4'd13;
    cfg_data = 8'sd5;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    collect(v, l);
    e = exp_q.pop_front();
    total++; if (l !== LAT - 2) begin bad++; $display("FAIL guard_hb_latency got=%0d want=%0d", l, LAT - 2); end
    total++; if (v !== e) begin bad++; $display("FAIL guard_hb_write got=%0d want=%0d", v, e); end
    cfg_write(14, 77);
    cfg_write(15, -3);
    drive(200, -100, 10);
    collect(v, l);
    e = exp_q.pop_front();
    total++; if (v !== e) begin bad++; $display("FAIL guard_bad_addr got=%0d want=%0d", v, e); end
  endtask

  task automatic test_random();
    int v, l, e, a, b;
    do_reset();
    for (int i = 0; i < NC; i++) cfg_write(i, int'($urandom_range(0, 255)) - 128);
    for (int i = 0; i < 6; i++) begin
      a = int'($urandom_range(0, 511)) - 256;
      b = int'($urandom_range(0, 511)) - 256;
      drive(a, b, model(a, b));
      collect(v, l);
      e = exp_q.pop_front();
      total++; if (v !== e) begin bad++; $display("FAIL random_out[%0d] x1=%0d x2=%0d got=%0d want=%0d", i, a, b, v, e); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, n, e;
    int at [2];
    int vals [2];
    at[0] = -1;
    at[1] = -1;
    @(negedge clk);
    x1 = 9'sd60;
    x2 = -9'sd45;
    in_valid = 1'b1;
    exp_q.push_back(model(60, -45));
    exp_q.push_back(model(60, -45));
    cyc = 0;
    n = 0;
    while (n < 2 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid === 1'b1) begin
        at[n] = cyc;
        vals[n] = int'(out1);
        n++;
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    total++; if (at[0] !== LAT + 1) begin bad++; $display("FAIL b2b_first got=%0d want=%0d", at[0], LAT + 1); end
    total++; if (at[1] - at[0] !== LAT + 2) begin bad++; $display("FAIL b2b_period got=%0d want=%0d", at[1] - at[0], LAT + 2); end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      total++; if (vals[i] !== e) begin bad++; $display("FAIL b2b_out[%0d] got=%0d want=%0d", i, vals[i], e); end
    end
  endtask

  task automatic test_backpressure();
    int v, l, e, stuck;
    out_ready = 1'b0;
    drive(-15, 120, model(-15, 120));
    collect(v, l);
    e = exp_q.pop_front();
    total++; if (l !== LAT) begin bad++; $display("FAIL bp_latency got=%0d want=%0d", l, LAT); end
    total++; if (v !== e) begin bad++; $display("FAIL bp_out got=%0d want=%0d", v, e); end
    stuck = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 5) begin
        in_valid = 1'b1;
        x1 = 9'sd255;
        x2 = -9'sd256;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (out_valid !== 1'b1 || int'(out1) !== e || in_ready !== 1'b0) stuck++;
    end
    total++; if (stuck !== 0) begin bad++; $display("FAIL bp_hold got=%0d bad cycles want=0", stuck); end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%0b want=1", in_ready); end
    total++; if (int'(out1) !== e) begin bad++; $display("FAIL bp_out_kept got=%0d want=%0d", out1, e); end
    stuck = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) stuck++;
    end
    total++; if (stuck !== 0) begin bad++; $display("FAIL bp_no_phantom got=%0d bad cycles want=0", stuck); end
  endtask

  task automatic test_reset_mid();
    int v, l, e;
    do_reset();
    cfg_write(12, 64);
    @(negedge clk);
    x1 = 9'sd0;
    x2 = 9'sd100;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NC; i++) sh[i] = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%0b want=1", in_ready); end
    drive(0, 100, 0);
    collect(v, l);
    e = exp_q.pop_front();
    total++; if (l !== LAT) begin bad++; $display("FAIL midrst_latency got=%0d want=%0d", l, LAT); end
    total++; if (v !== e) begin bad++; $display("FAIL midrst_cleared got=%0d want=%0d", v, e); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    x1        = '0;
    x2        = '0;
    test_reset();
    test_w2x();
    test_hidden();
    test_cfg_guard();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
